// File: rtl/ddr_out_serializer.sv
// ddr_out_serializer: word-to-DDR-pair serializer with lead/trail framing, CE and registered tristate control
module ddr_out_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   LEAD       = 1,
    parameter int   TRAIL      = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             D0,
    output logic             D1,
    output logic             CE,
    output logic             T,
    output logic             busy
);
    localparam logic [15:0] NP        = 16'(WIDTH / 2);
    localparam logic [15:0] LEAD_END  = 16'(LEAD > 0 ? LEAD - 1 : 0);
    localparam logic [15:0] TRAIL_END = 16'(TRAIL > 0 ? TRAIL - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hold, r_sh;
    logic             r_full, r_t;
    logic             w_load, w_acc, w_pair;

    // In SHIFT, count 0 is the cycle in which the freshly loaded word is primed; counts 1..WIDTH/2 put pairs out.
    assign in_ready = ~r_full & ~R;
    assign w_acc    = in_valid & in_ready;
    assign w_pair   = (r_state == S_SHIFT) && (r_cnt != 16'd0);
    assign D0       = w_pair ? r_sh[WIDTH-1] : IDLE_LEVEL;
    assign D1       = w_pair ? r_sh[WIDTH-2] : IDLE_LEVEL;
    assign CE       = r_state != S_IDLE;
    assign T        = r_t;
    assign busy     = CE | r_full;

    // Next state, phase counter and shifter-load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (r_full) begin
                    w_state_nxt = (LEAD == 0) ? S_SHIFT : S_LEAD;
                    w_load      = LEAD == 0;
                end
            end
            S_LEAD: begin
                if (r_cnt == LEAD_END) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_SHIFT: begin
                if (r_cnt == NP) begin
                    w_load      = r_full;
                    w_cnt_nxt   = r_full ? 16'd1 : 16'd0;
                    w_state_nxt = r_full ? S_SHIFT : (TRAIL == 0) ? S_IDLE : S_TRAIL;
                end
            end
            S_TRAIL: begin
                // A word arriving on the trail's closing edge keeps the trail alive so it can start without a lead.
                if (r_full) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                    w_cnt_nxt   = 16'd0;
                end else if (w_acc) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt == TRAIL_END) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and phase counter registers.
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Holding register: filled by the handshake, emptied when the shifter takes it.
    always_ff @(posedge C) begin
        if (R || w_load) begin
            r_full <= 1'b0;
        end else if (w_acc) begin
            r_full <= 1'b1;
            r_hold <= in_data;
        end
    end

    // Shift register, MSB pair first.
    always_ff @(posedge C) begin
        if (w_load) begin
            r_sh <= r_hold;
        end else if (w_pair) begin
            r_sh <= r_sh << 2;
        end
    end

    // Tristate control lags the state by one edge to line up with the DDR cell's own register.
    always_ff @(posedge C) begin
        r_t <= R | (r_state == S_IDLE);
    end
endmodule

// File: tb/tb_ddr_out_serializer.sv
// tb_ddr_out_serializer: directed and random scoreboard bench for two serializer configurations
module tb_ddr_out_serializer;
    typedef struct {
        logic [7:0] w;
        int         a;
    } acc_t;

    logic       C = 1'b0;
    logic       rst [2];
    logic       vld [2];
    logic [7:0] din [2];
    logic       rdyo [2];
    logic       d0o [2];
    logic       d1o [2];
    logic       ceo [2];
    logic       to [2];
    logic       busyo [2];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    initial forever #5 C = ~C;

    always @(posedge C) cyc <= cyc + 1;

    ddr_out_serializer #(.WIDTH(8), .LEAD(1), .TRAIL(1), .IDLE_LEVEL(1'b0)) u0 (
        .C(C), .R(rst[0]), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdyo[0]),
        .D0(d0o[0]), .D1(d1o[0]), .CE(ceo[0]), .T(to[0]), .busy(busyo[0])
    );

    ddr_out_serializer #(.WIDTH(8), .LEAD(0), .TRAIL(0), .IDLE_LEVEL(1'b0)) u1 (
        .C(C), .R(rst[1]), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdyo[1]),
        .D0(d0o[1]), .D1(d1o[1]), .CE(ceo[1]), .T(to[1]), .busy(busyo[1])
    );

    // Per instance: log handshakes into a queue with their edge number, and a monitor that
    // predicts when each word's pairs appear and rebuilds the word from D0/D1.
    for (genvar g = 0; g < 2; g++) begin : m
        localparam int LD = (g == 0) ? 1 : 0;
        localparam int TR = (g == 0) ? 1 : 0;
        acc_t       q[$];
        int         n_acc = 0;
        logic       act = 1'b0;
        int         st, k, a;
        int         t_last = -1000;
        logic [7:0] got, w;
        logic       ok;

        initial forever begin
            @(posedge C);
            if (vld[g] && rdyo[g]) begin
                q.push_back('{din[g], cyc + 1});
                n_acc++;
            end
        end

        initial forever begin
            @(posedge C);
            #1;
            if (rst[g]) begin
                q.delete();
                act = 1'b0;
                t_last = -1000;
            end else begin
                if (act && cyc == st + k) begin
                    got = {got[5:0], d0o[g], d1o[g]};
                    ok = ok && ceo[g] && !to[g];
                    k++;
                    if (k == 4) begin
                        n_chk++;
                        if (got !== w || !ok) begin
                            n_fail++;
                            $display("FAIL word inst%0d: got %h (ce/t framing ok=%0d), expected %h at edges %0d..%0d",
                                     g, got, ok, w, st, st + 3);
                        end
                        t_last = cyc;
                        act = 1'b0;
                    end
                end
                if (!act && q.size() > 0) begin
                    w = q[0].w;
                    a = q[0].a;
                    q.pop_front();
                    st = (a <= t_last) ? t_last + 1 :
                         (TR > 0 && a <= t_last + TR + 1) ? a + 2 : a + LD + 2;
                    k = 0;
                    ok = 1'b1;
                    act = 1'b1;
                end
            end
        end
    end

    function automatic logic [5:0] outs(input int g);
        return {busyo[g], rdyo[g], ceo[g], to[g], d0o[g], d1o[g]};
    endfunction

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b {busy,in_ready,CE,T,D0,D1}", nm, act, exp);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge C);
    endtask

    task automatic send(input int g, input logic [7:0] wd);
        logic hit = 1'b0;
        vld[g] = 1'b1;
        din[g] = wd;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge C);
            hit = rdyo[g];
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL send inst%0d: word %h not accepted within 100 cycles", g, wd);
        end
        @(negedge C);
    endtask

    initial begin
        int   e0, e1, base;
        logic dr;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            vld[g] = 1'b0;
            din[g] = 8'h00;
        end
        repeat (3) @(negedge C);
        chk("reset inst0", outs(0), 6'b000100);
        chk("reset inst1", outs(1), 6'b000100);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        chk("ready after reset inst0", outs(0), 6'b010100);
        chk("ready after reset inst1", outs(1), 6'b010100);
        @(negedge C);

        send(0, 8'hA5); e0 = cyc; vld[0] = 1'b0;
        chk("A5 held", outs(0), 6'b100100);
        at(e0 + 1); chk("A5 lead", outs(0), 6'b101100);
        at(e0 + 2); chk("A5 T low before pair0", outs(0), 6'b111000);
        at(e0 + 3); chk("A5 pair0", outs(0), 6'b111010);
        at(e0 + 7); chk("A5 trail", outs(0), 6'b111000);
        at(e0 + 8); chk("A5 idle CE low", outs(0), 6'b010000);
        at(e0 + 9); chk("A5 T high", outs(0), 6'b010100);

        base = m[0].n_acc;
        send(0, 8'hA5); e0 = cyc;
        send(0, 8'h3C); e1 = cyc; vld[0] = 1'b0;
        chk("refill edge", 6'(e1 - e0), 6'd3);
        chk("both registers full", outs(0), 6'b101010);
        at(e0 + 8); chk("3C pair1 no gap", outs(0), 6'b111011);
        at(e0 + 12); chk("b2b idle", outs(0), 6'b010000);
        chk("two handshakes", 6'(m[0].n_acc - base), 6'd2);
        at(e0 + 14);

        send(1, 8'hFF); e0 = cyc; vld[1] = 1'b0;
        chk("FF held", outs(1), 6'b100100);
        at(e0 + 1); chk("FF left idle", outs(1), 6'b111100);
        at(e0 + 2); chk("FF pair0", outs(1), 6'b111011);
        at(e0 + 5); chk("FF pair3", outs(1), 6'b111011);
        at(e0 + 6); chk("FF idle after pair3", outs(1), 6'b010000);
        at(e0 + 7); chk("FF T high", outs(1), 6'b010100);

        send(0, 8'h5A); e0 = cyc; vld[0] = 1'b0;
        at(e0 + 7); chk("5A trail", outs(0), 6'b111000);
        vld[0] = 1'b1; din[0] = 8'h81;
        at(e0 + 8); chk("81 accepted in trail", outs(0), 6'b101000);
        vld[0] = 1'b0;
        at(e0 + 9); chk("81 no lead", outs(0), 6'b111000);
        at(e0 + 10); chk("81 pair0", outs(0), 6'b111010);
        at(e0 + 15); chk("81 idle", outs(0), 6'b010000);
        at(e0 + 16); chk("81 T high", outs(0), 6'b010100);

        send(0, 8'hC3); e0 = cyc;
        send(0, 8'h77); vld[0] = 1'b0;
        at(e0 + 4); chk("C3 pair1 with held word", outs(0), 6'b101000);
        rst[0] = 1'b1;
        at(e0 + 5); chk("reset mid-burst", outs(0), 6'b000100);
        rst[0] = 1'b0;
        at(e0 + 7); chk("held word dropped by reset", outs(0), 6'b010100);
        at(e0 + 12); chk("still idle after reset", outs(0), 6'b010100);

        for (int i = 0; i < 10000; i++) begin
            for (int g = 0; g < 2; g++) begin
                vld[g] = int'($urandom_range(0, 3)) >= (i / 500) % 4;
                din[g] = 8'($urandom);
            end
            @(negedge C);
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        dr = 1'b0;
        for (int i = 0; i < 100 && !dr; i++) begin
            @(negedge C);
            dr = m[0].q.size() == 0 && !m[0].act && m[1].q.size() == 0 && !m[1].act;
        end
        chk("random drain", {5'd0, dr}, 6'd1);
        repeat (5) @(negedge C);
        chk("final idle inst0", outs(0), 6'b010100);
        chk("final idle inst1", outs(1), 6'b010100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_out_serializer.md
# ddr_out_serializer

Parallel-to-DDR serializer feeding the dual-data-rate tristate output flop stage. Accepts WIDTH-bit words over a valid/ready handshake and emits two bits per C cycle on D0/D1, MSB first. Generates the downstream CE and the tristate control T, with configurable lead and trail cycles of driven idle level around each burst. Sits directly upstream of the DDR output cell; its outputs connect to that cell's D0, D1, CE and T pins.

## Interface
- WIDTH, 8: word width; even, ≥ 2; one word = WIDTH/2 cycles.
- LEAD, 1: cycles of driven IDLE_LEVEL before the first pair of a burst (0 allowed).
- TRAIL, 1: cycles of driven IDLE_LEVEL after the last pair of a burst (0 allowed).
- IDLE_LEVEL, 1'b0: value on D0/D1 whenever no data pair is being sent.

- C  in  1  clock; all logic on rising edge.
- R  in  1  reset; synchronous, active-high.
- in_data  in  WIDTH  word to send.
- in_valid  in  1  in_data valid.
- in_ready  out  1  holding register empty; transfer on in_valid & in_ready at an edge.
- D0  out  1  bit for the first half-cycle (C0 edge of the DDR cell).
- D1  out  1  bit for the second half-cycle (C1 edge).
- CE  out  1  clock enable to the DDR cell.
- T  out  1  tristate control; 1 = high-Z, 0 = drive.
- busy  out  1  state ≠ IDLE or holding register full.

## Operation
- Storage: one holding register plus one shift register. in_ready = ~hold_full, and is 0 while R is high.
- Bit order: pair k (k = 0..WIDTH/2-1) is D0 = W[WIDTH-1-2k], D1 = W[WIDTH-2-2k].
- States:
  - IDLE: D0 = D1 = IDLE_LEVEL, CE = 0, T = 1. A word in the holding register moves to LEAD, or to SHIFT when LEAD = 0.
  - LEAD: counts LEAD cycles with D0 = D1 = IDLE_LEVEL and CE = 1, then goes to SHIFT.
  - SHIFT: on entry, loads the holding register into the shifter, freeing the holding register. Issues one pair per cycle with CE = 1. After the last pair, a full holding register reloads on the next edge and SHIFT continues with no gap. Otherwise the block goes to TRAIL, or to IDLE when TRAIL = 0.
  - TRAIL: counts TRAIL cycles with D0 = D1 = IDLE_LEVEL and CE = 1, then goes to IDLE. A word accepted during TRAIL aborts the trail and goes straight to SHIFT on the next edge, with no LEAD.
- T is a register: T = 0 one edge after the state first leaves IDLE, and T = 1 one edge after the state returns to IDLE. This lag matches the one-cycle latency of the downstream DDR flop.
- Inputs are ignored while in_ready = 0; no word is ever dropped or duplicated.

## Timing
- Reset values, forced at the reset edge with no T lag: state = IDLE, hold empty, D0 = D1 = IDLE_LEVEL, CE = 0, T = 1, busy = 0, in_ready = 0. in_ready becomes 1 in the first cycle after R falls.
- Word accepted at edge e0 in IDLE:
  - State leaves IDLE at edge e0 + 1.
  - LEAD cycles run after that.
  - Pair 0 is on D0/D1 after edge e0 + LEAD + 2.
  - Pair k is on D0/D1 after edge e0 + LEAD + 2 + k.
- Sustained throughput: one word per WIDTH/2 cycles. While the current word shifts, the holding register refills and in_ready drops for one word time.
- Last pair at edge t with the next word held: next pair 0 at edge t + 1.
- Last burst pair at edge t:
  - TRAIL idle cycles run at edges t + 1 .. t + TRAIL.
  - CE falls and the state enters IDLE at edge t + TRAIL + 1.
  - T rises at edge t + TRAIL + 2.
- R high mid-burst: the partial word is abandoned, the held word is discarded, and all outputs take their reset values at that edge.
- in_valid held with unchanged data while in_ready = 0 is legal; data may also change freely when in_valid = 0.

## Test plan
- WIDTH = 8, LEAD = 1, TRAIL = 1, single 0xA5 -> pairs (1,0),(1,0),(0,1),(0,1); T low from the cycle before pair 0 through the trail cycle; CE = 0 afterwards.
- Back-to-back 0xA5, 0x3C with in_valid held -> 8 consecutive pairs with no idle gap; in_ready low while both registers are full; exactly two handshakes.
- LEAD = 0, TRAIL = 0, single 0xFF -> pair 0 one edge after the state leaves IDLE; IDLE reentered right after pair 3.
- Word 0x81 presented during TRAIL -> trail aborted, pairs (1,0),(0,0),(0,0),(0,1), no LEAD cycle; T stays 0 throughout.
- R asserted after pair 1 of 0xC3 with a second word held -> next cycle D0 = D1 = 0, T = 1, CE = 0, busy = 0; the held word is never sent.
- Random valid/data with random in_valid gaps over 10k cycles -> scoreboard reconstructs every accepted word in order from D0/D1 while CE = 1 and T = 0.
